// File: rtl/mips_cache_pkg.sv
// rtl/mips_cache_pkg.sv - shared state type and default geometry for the instruction cache
package mips_cache_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_t;

   localparam int unsigned DEF_LINES      = 16;
   localparam int unsigned DEF_LINE_WORDS = 4;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - tag, data and valid storage for the direct-mapped instruction cache
module icache_array
   import mips_cache_pkg::*;
#(
   parameter int unsigned LINES      = DEF_LINES,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
   parameter int unsigned IDX_W      = $clog2(LINES),
   parameter int unsigned WORD_W     = $clog2(LINE_WORDS),
   parameter int unsigned TAG_W      = 30 - IDX_W - WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [IDX_W-1:0]  rd_index,
   input  logic [WORD_W-1:0] rd_word,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [31:0]       rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [WORD_W-1:0] wr_word,
   input  logic [31:0]       wr_data,
   input  logic              fill_done,
   input  logic [TAG_W-1:0]  fill_tag
);

   logic [31:0]      data_q [LINES*LINE_WORDS];
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [LINES-1:0] valid_q;

   // flush outranks a completing fill so an aborted line never becomes valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (fill_done) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[{wr_index, wr_word}] <= wr_data;
      end
      if (fill_done) begin
         tag_q[wr_index] <= fill_tag;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[{rd_index, rd_word}];

endmodule

// File: rtl/icache_fill.sv
// rtl/icache_fill.sv - direct-mapped instruction cache with zero-cycle hit and line refill FSM
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fill
   import mips_cache_pkg::*;
#(
   parameter int unsigned LINES      = DEF_LINES,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] instr,
   output logic        ready,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned WORD_W = $clog2(LINE_WORDS);
   localparam int unsigned TAG_W  = 30 - IDX_W - WORD_W;
   localparam int unsigned LA_W   = 30 - WORD_W;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

   state_t            state_q;
   logic [WORD_W-1:0] cnt_q;
   logic [LA_W-1:0]   line_q;
   logic              mem_req_q;

   logic [WORD_W-1:0] pc_word;
   logic [IDX_W-1:0]  pc_index;
   logic [TAG_W-1:0]  pc_tag;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [31:0]       rd_data;
   logic              lookup_hit;
   logic              hit;
   logic              wr_en;
   logic              fill_done;
   logic              unused_pc_bits;

   assign pc_word        = pc[2 +: WORD_W];
   assign pc_index       = pc[2 + WORD_W +: IDX_W];
   assign pc_tag         = pc[31 -: TAG_W];
   assign unused_pc_bits = ^pc[1:0];

   assign lookup_hit = rd_valid && (rd_tag == pc_tag);
   assign hit        = (state_q == IDLE) && lookup_hit;
   assign ready      = hit && !flush;
   assign instr      = ready ? rd_data : 32'h0;

   assign wr_en     = mem_req_q && mem_ack;
   assign fill_done = wr_en && (cnt_q == LAST_WORD) && !flush;
   assign mem_req   = mem_req_q;
   assign mem_addr  = {line_q, cnt_q, 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         line_q    <= '0;
         mem_req_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!lookup_hit) begin
                  state_q   <= REFILL;
                  line_q    <= pc[31 : 2 + WORD_W];
                  cnt_q     <= '0;
                  mem_req_q <= 1'b1;
               end
            end
            REFILL: begin
               // pc is not looked at here; the latched line address drives the whole refill
               if (flush) begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  mem_req_q <= 1'b0;
               end else if (mem_ack) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_WORD) begin
                     state_q   <= IDLE;
                     cnt_q     <= '0;
                     mem_req_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit) begin
            hit_count <= hit_count + 32'd1;
         end
         if ((state_q == IDLE) && !lookup_hit) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

   icache_array #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS)
   ) u_array (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .rd_index  (pc_index),
      .rd_word   (pc_word),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_index  (line_q[IDX_W-1:0]),
      .wr_word   (cnt_q),
      .wr_data   (mem_rdata),
      .fill_done (fill_done),
      .fill_tag  (line_q[LA_W-1 -: TAG_W])
   );

endmodule

// File: tb/tb_icache_fill.sv
// tb/tb_icache_fill.sv - directed self-checking bench for icache_fill
module tb_icache_fill;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        ready;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   logic        ack_tied;
   logic        ack_slow;
   logic [1:0]  wait_cnt = 2'd0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n;

   always #5 clk = ~clk;

   // backing memory: each word is its own address with a fixed pattern mixed in
   assign mem_rdata = mem_addr ^ 32'hCAFE_0000;
   assign mem_ack   = ack_tied | (ack_slow & mem_req & (wait_cnt == 2'd3));

   always @(posedge clk) begin
      if (!mem_req || mem_ack) wait_cnt <= 2'd0;
      else                     wait_cnt <= wait_cnt + 2'd1;
   end

   icache_fill dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .instr     (instr),
      .ready     (ready),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      pc       = 32'h0040_0000;
      flush    = 1'b0;
      ack_tied = 1'b1;
      ack_slow = 1'b0;
      step();
      step();
      check_eq("rst_ready", {31'd0, ready}, 32'd0);
      check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("rst_instr", instr, 32'h0);

      // cold miss with ack tied high: 1 + LINE_WORDS stall cycles
      reset = 1'b0;
      settle();
      n = 0;
      while (!ready && n < 20) begin
         if (mem_req) check_eq("fill_addr", mem_addr, 32'h0040_0000 + 32'(4 * (n - 1)));
         step();
         n++;
      end
      check_eq("miss_latency", n, 32'd5);
      check_eq("fill_instr0", instr, 32'hCABE_0000);

      pc = 32'h0040_000C;
      settle();
      check_eq("hit_ready", {31'd0, ready}, 32'd1);
      check_eq("hit_instr", instr, 32'hCABE_000C);
      check_eq("hit_no_req", {31'd0, mem_req}, 32'd0);
      pc = 32'h0040_0004;
      settle();
      check_eq("hit_instr1", instr, 32'hCABE_0004);

      // same index, new tag replaces the line; the old tag then misses
      pc = 32'h0040_0100;
      settle();
      check_eq("conflict_miss", {31'd0, ready}, 32'd0);
      check_eq("conflict_instr0", instr, 32'h0);
      n = 0;
      while (!ready && n < 20) begin step(); n++; end
      check_eq("conflict_latency", n, 32'd5);
      check_eq("conflict_instr", instr, 32'hCABE_0100);
      pc = 32'h0040_0000;
      settle();
      check_eq("evicted_miss", {31'd0, ready}, 32'd0);
      n = 0;
      while (!ready && n < 20) begin step(); n++; end
      check_eq("evicted_refill", instr, 32'hCABE_0000);

      // slow memory, pc moved to a resident line mid-refill
      ack_tied = 1'b0;
      ack_slow = 1'b1;
      pc = 32'h0040_0210;
      settle();
      check_eq("slow_miss", {31'd0, ready}, 32'd0);
      step();
      pc = 32'h0040_0000;
      settle();
      check_eq("refill_pc_change", {31'd0, ready}, 32'd0);
      check_eq("refill_addr0", mem_addr, 32'h0040_0210);
      n = 0;
      while (mem_req && n < 60) begin step(); n++; end
      check_eq("slow_refill_cycles", n, 32'd16);
      check_eq("slow_other_hit", instr, 32'hCABE_0000);
      for (int i = 0; i < 4; i++) begin
         pc = 32'h0040_0210 + 32'(4 * i);
         settle();
         check_eq("slow_word_ready", {31'd0, ready}, 32'd1);
         check_eq("slow_word", instr, 32'hCABE_0210 + 32'(4 * i));
      end

      // flush while idle on a hit
      pc    = 32'h0040_0214;
      flush = 1'b1;
      settle();
      check_eq("flush_ready", {31'd0, ready}, 32'd0);
      check_eq("flush_instr", instr, 32'h0);
      step();
      flush = 1'b0;
      settle();
      check_eq("post_flush_miss", {31'd0, ready}, 32'd0);

      // reset part-way through a refill drops mem_req at once
      step();
      step();
      check_eq("pre_rst_req", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      settle();
      check_eq("mid_rst_req", {31'd0, mem_req}, 32'd0);

      // flush lands on the last ack: line stays invalid
      ack_slow = 1'b0;
      ack_tied = 1'b1;
      pc       = 32'h0040_0000;
      step();
      step();
      reset = 1'b0;
      settle();
      check_eq("f4_idle_miss", {31'd0, ready}, 32'd0);
      step();
      step();
      step();
      step();
      flush = 1'b1;
      settle();
      check_eq("f4_last_addr", mem_addr, 32'h0040_000C);
      check_eq("f4_ready", {31'd0, ready}, 32'd0);
      step();
      flush = 1'b0;
      settle();
      check_eq("f4_still_invalid", {31'd0, ready}, 32'd0);
      check_eq("f4_req_dropped", {31'd0, mem_req}, 32'd0);
      step();
      check_eq("f4_refetch_req", {31'd0, mem_req}, 32'd1);
`ifdef ICACHE_STATS_EN
      check_eq("stat_miss", miss_count, 32'd2);
      check_eq("stat_hit", hit_count, 32'd0);
`endif
      n = 0;
      while (!ready && n < 20) begin step(); n++; end
      check_eq("f4_refetch_instr", instr, 32'hCABE_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
